// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: command codes,
// status bit positions and FSM state encoding.
package alu_arb_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned STAT_W = 4;

    // Bit positions inside the {N,Z,C,V} status word
    localparam int unsigned ST_N = 3;
    localparam int unsigned ST_Z = 2;
    localparam int unsigned ST_C = 1;
    localparam int unsigned ST_V = 0;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_AND = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_EOR = 4'b1000;
    localparam logic [CMD_W-1:0] CMD_MVN = 4'b1001;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant logic. With ALU_ARB_RR_EN defined a pointer alternates the
// preferred requester after every grant; otherwise req0 always wins.
module arb_rr2 (
`ifdef ALU_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prefer1;

`ifdef ALU_ARB_RR_EN
    // Pointer names the requester that wins the next contention
    always_ff @(posedge clk) begin
        if (rst) begin
            prefer1 <= 1'b0;
        end else if (gnt != 2'b00) begin
            prefer1 <= gnt[0];
        end
    end
`else
    assign prefer1 = 1'b0;
`endif

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && req[1]) begin
                gnt = prefer1 ? 2'b10 : 2'b01;
            end else if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters and holds a
// single registered response. Build option: ALU_ARB_RR_EN (round-robin).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_cmd,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic              req0_s,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_cmd,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic              req1_s,

    output logic [3:0]        alu_command,
    output logic [3:0]        alu_status_in,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_status,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_status,

    output logic [3:0]        status_q
);

    arb_state_t state;
    logic       accept;
    logic [1:0] gnt;
    logic       gnt_any;
    logic       gnt_s;

    // A new op may enter when the response slot is empty or being drained
    assign accept  = !rst && ((state == S_IDLE) || rsp_ready);
    assign gnt_any = gnt[0] | gnt[1];

    arb_rr2 u_arb (
`ifdef ALU_ARB_RR_EN
        .clk (clk),
        .rst (rst),
`endif
        .en  (accept),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    assign req0_ready    = gnt[0];
    assign req1_ready    = gnt[1];
    assign alu_status_in = status_q;

    always_comb begin
        alu_command  = CMD_NOP;
        alu_operand1 = '0;
        alu_operand2 = '0;
        gnt_s        = 1'b0;
        if (gnt[0]) begin
            alu_command  = req0_cmd;
            alu_operand1 = req0_op1;
            alu_operand2 = req0_op2;
            gnt_s        = req0_s;
        end else if (gnt[1]) begin
            alu_command  = req1_cmd;
            alu_operand1 = req1_op1;
            alu_operand2 = req1_op2;
            gnt_s        = req1_s;
        end
    end

    // Response slot and architectural status; a grant captures the ALU output
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_status <= 4'b0000;
            status_q   <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= gnt[1];
                        rsp_result <= alu_result;
                        rsp_status <= alu_status;
                        if (gnt_s) begin
                            status_q <= alu_status;
                        end
                    end
                end
                S_RESP: begin
                    if (gnt_any) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= gnt[1];
                        rsp_result <= alu_result;
                        rsp_status <= alu_status;
                        if (gnt_s) begin
                            status_q <= alu_status;
                        end
                    end else if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached.
// Expected grant order depends on ALU_ARB_RR_EN.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_s;
    logic [3:0]    req0_cmd;
    logic [DW-1:0] req0_op1, req0_op2;
    logic          req1_valid, req1_ready, req1_s;
    logic [3:0]    req1_cmd;
    logic [DW-1:0] req1_op1, req1_op2;
    logic [3:0]    alu_command, alu_status_in, alu_status;
    logic [DW-1:0] alu_operand1, alu_operand2, alu_result;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [DW-1:0] rsp_result;
    logic [3:0]    rsp_status, status_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_s(req1_s),
        .alu_command(alu_command), .alu_status_in(alu_status_in),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_result(alu_result), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_status(rsp_status), .status_q(status_q)
    );

    // Behavioural ALU: arithmetic sets NZCV, logic ops keep C and V
    logic [DW:0]   sum;
    logic [DW-1:0] opb;
    logic          cin, is_arith;
    always_comb begin
        sum = '0; opb = alu_operand2; cin = 1'b0; is_arith = 1'b0;
        alu_result = '0;
        case (alu_command)
            CMD_MOV: alu_result = alu_operand2;
            CMD_MVN: alu_result = ~alu_operand2;
            CMD_AND: alu_result = alu_operand1 & alu_operand2;
            CMD_ORR: alu_result = alu_operand1 | alu_operand2;
            CMD_EOR: alu_result = alu_operand1 ^ alu_operand2;
            CMD_ADD: begin is_arith = 1'b1; end
            CMD_ADC: begin is_arith = 1'b1; cin = alu_status_in[ST_C]; end
            CMD_SUB: begin is_arith = 1'b1; opb = ~alu_operand2; cin = 1'b1; end
            CMD_SBC: begin is_arith = 1'b1; opb = ~alu_operand2; cin = alu_status_in[ST_C]; end
            default: alu_result = '0;
        endcase
        if (is_arith) begin
            sum = {1'b0, alu_operand1} + {1'b0, opb} + (DW+1)'(cin);
            alu_result = sum[DW-1:0];
        end
        alu_status = alu_status_in;
        if (alu_command != CMD_NOP) begin
            alu_status[ST_N] = alu_result[DW-1];
            alu_status[ST_Z] = (alu_result == '0);
            if (is_arith) begin
                alu_status[ST_C] = sum[DW];
                alu_status[ST_V] = (alu_operand1[DW-1] == opb[DW-1]) &&
                                   (alu_result[DW-1] != alu_operand1[DW-1]);
            end
        end
    end

    typedef struct {
        logic v0; logic [3:0] c0; logic [31:0] a0, b0; logic s0;
        logic v1; logic [3:0] c1; logic [31:0] a1, b1; logic s1;
        logic rr;
        logic e_rdy0, e_rdy1, e_valid, e_id;
        logic [31:0] e_res; logic [3:0] e_st, e_sq;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic v0, input logic [3:0] c0, input logic [31:0] a0, b0, input logic s0,
        input logic v1, input logic [3:0] c1, input logic [31:0] a1, b1, input logic s1,
        input logic rr, input logic e_rdy0, e_rdy1, e_valid, e_id,
        input logic [31:0] e_res, input logic [3:0] e_st, e_sq);
        vec_t v;
        v.v0 = v0; v.c0 = c0; v.a0 = a0; v.b0 = b0; v.s0 = s0;
        v.v1 = v1; v.c1 = c1; v.a1 = a1; v.b1 = b1; v.s1 = s1;
        v.rr = rr; v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1;
        v.e_valid = e_valid; v.e_id = e_id;
        v.e_res = e_res; v.e_st = e_st; v.e_sq = e_sq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set0(input logic v, input logic [3:0] c, input logic [31:0] a, b, input logic s);
        req0_valid = v; req0_cmd = c; req0_op1 = a; req0_op2 = b; req0_s = s;
    endtask

    task automatic set1(input logic v, input logic [3:0] c, input logic [31:0] a, b, input logic s);
        req1_valid = v; req1_cmd = c; req1_op1 = a; req1_op2 = b; req1_s = s;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  exp_id_rr;
    logic [31:0] exp_res_rr;
    logic        hold_id;
    logic [31:0] hold_res;

    initial begin
        vecs[0] = mk(1, CMD_ADD, 32'h7FFF_FFFF, 32'h1, 1, 0, CMD_NOP, 0, 0, 0,
                     1, 1, 0, 1, 0, 32'h8000_0000, 4'b1001, 4'b1001);
        vecs[1] = mk(1, CMD_SUB, 32'h5, 32'h7, 0, 0, CMD_NOP, 0, 0, 0,
                     1, 1, 0, 1, 0, 32'hFFFF_FFFE, 4'b1000, 4'b1001);
        vecs[2] = mk(1, CMD_ADD, 32'hFFFF_FFFF, 32'h1, 1, 0, CMD_NOP, 0, 0, 0,
                     1, 1, 0, 1, 0, 32'h0, 4'b0110, 4'b0110);
        vecs[3] = mk(1, CMD_ADC, 32'h0, 32'h0, 1, 0, CMD_NOP, 0, 0, 0,
                     1, 1, 0, 1, 0, 32'h1, 4'b0000, 4'b0000);
        vecs[4] = mk(0, CMD_NOP, 0, 0, 0, 1, CMD_MOV, 32'h0, 32'h1234, 1,
                     1, 0, 1, 1, 1, 32'h1234, 4'b0000, 4'b0000);
        vecs[5] = mk(0, CMD_NOP, 0, 0, 0, 0, CMD_NOP, 0, 0, 0,
                     1, 0, 0, 0, 1, 32'h1234, 4'b0000, 4'b0000);
        vecs[6] = mk(0, CMD_NOP, 0, 0, 0, 1, CMD_EOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 0,
                     1, 0, 1, 1, 1, 32'h0F0F_0F0F, 4'b0000, 4'b0000);
        vecs[7] = mk(0, CMD_NOP, 0, 0, 0, 1, CMD_AND, 32'hFF00, 32'h00FF, 1,
                     1, 0, 1, 1, 1, 32'h0, 4'b0100, 4'b0100);
        vecs[8] = mk(1, CMD_ORR, 32'h1, 32'h2, 1, 1, CMD_MVN, 32'h0, 32'h0, 1,
                     1, 1, 0, 1, 0, 32'h3, 4'b0000, 4'b0000);

        rst = 1'b1; rsp_ready = 1'b1;
        set0(0, CMD_NOP, 0, 0, 0); set1(0, CMD_NOP, 0, 0, 0);
        after_edge();
        after_edge();
        chk("reset rsp_valid",  32'(rsp_valid),  32'h0);
        chk("reset rsp_id",     32'(rsp_id),     32'h0);
        chk("reset rsp_result", rsp_result,      32'h0);
        chk("reset rsp_status", 32'(rsp_status), 32'h0);
        chk("reset status_q",   32'(status_q),   32'h0);

        @(negedge clk);
        rst = 1'b0;

        // Table: one row per cycle, state carries from row to row
        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            set0(vecs[i].v0, vecs[i].c0, vecs[i].a0, vecs[i].b0, vecs[i].s0);
            set1(vecs[i].v1, vecs[i].c1, vecs[i].a1, vecs[i].b1, vecs[i].s1);
            rsp_ready = vecs[i].rr;
            #1;
            chk($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].e_rdy0));
            chk($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].e_rdy1));
            after_edge();
            chk($sformatf("v%0d rsp_valid", i),  32'(rsp_valid),  32'(vecs[i].e_valid));
            chk($sformatf("v%0d rsp_id", i),     32'(rsp_id),     32'(vecs[i].e_id));
            chk($sformatf("v%0d rsp_result", i), rsp_result,      vecs[i].e_res);
            chk($sformatf("v%0d rsp_status", i), 32'(rsp_status), 32'(vecs[i].e_st));
            chk($sformatf("v%0d status_q", i),   32'(status_q),   32'(vecs[i].e_sq));
        end

        // Contention for 4 cycles from a fresh reset
        @(negedge clk);
        rst = 1'b1; set0(0, CMD_NOP, 0, 0, 0); set1(0, CMD_NOP, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1;
        set0(1, CMD_MOV, 0, 32'hA, 0); set1(1, CMD_MOV, 0, 32'hB, 0);
`ifdef ALU_ARB_RR_EN
        exp_id_rr = 4'b1010;
`else
        exp_id_rr = 4'b0000;
`endif
        for (int k = 0; k < 4; k++) begin
            after_edge();
            exp_res_rr = exp_id_rr[k] ? 32'hB : 32'hA;
            chk($sformatf("contend%0d rsp_id", k), 32'(rsp_id), 32'(exp_id_rr[k]));
            chk($sformatf("contend%0d rsp_result", k), rsp_result, exp_res_rr);
        end
        hold_id  = exp_id_rr[3];
        hold_res = exp_id_rr[3] ? 32'hB : 32'hA;

        // Backpressure: response frozen, no grants, status untouched
        @(negedge clk);
        rsp_ready = 1'b0;
        set0(1, CMD_ADD, 32'h7FFF_FFFF, 32'h1, 1); set1(0, CMD_NOP, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk($sformatf("bp%0d req0_ready", k), 32'(req0_ready), 32'h0);
            chk($sformatf("bp%0d req1_ready", k), 32'(req1_ready), 32'h0);
            after_edge();
            chk($sformatf("bp%0d rsp_valid", k),  32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d rsp_id", k),     32'(rsp_id),    32'(hold_id));
            chk($sformatf("bp%0d rsp_result", k), rsp_result,     hold_res);
            chk($sformatf("bp%0d status_q", k),   32'(status_q),  32'h0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp release req0_ready", 32'(req0_ready), 32'h1);
        after_edge();
        chk("bp release rsp_result", rsp_result,      32'h8000_0000);
        chk("bp release rsp_status", 32'(rsp_status), 32'h9);
        chk("bp release status_q",   32'(status_q),   32'h9);
        chk("bp release rsp_id",     32'(rsp_id),     32'h0);

        // Reset while holding a response
        @(negedge clk);
        rst = 1'b1; rsp_ready = 1'b0;
        set0(1, CMD_SUB, 32'h5, 32'h7, 1);
        #1;
        chk("rst req0_ready", 32'(req0_ready), 32'h0);
        after_edge();
        chk("rst rsp_valid",  32'(rsp_valid), 32'h0);
        chk("rst status_q",   32'(status_q),  32'h0);
        chk("rst rsp_result", rsp_result,     32'h0);
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b0;
        set0(1, CMD_ADD, 32'hFFFF_FFFF, 32'h1, 1);
        #1;
        chk("post-rst idle req0_ready", 32'(req0_ready), 32'h1);
        after_edge();
        chk("post-rst rsp_valid",  32'(rsp_valid), 32'h1);
        chk("post-rst rsp_result", rsp_result,     32'h0);
        chk("post-rst status_q",   32'(status_q),  32'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width.
REQ-002 SHALL have port: clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have ports: req0_valid/req1_valid  in  1  requester N has an operation pending.
REQ-005 SHALL have ports: req0_ready/req1_ready  out  1  requester N's operation is accepted this cycle.
REQ-006 SHALL have ports: reqN_cmd  in  4  ALU command; reqN_op1, reqN_op2  in  DATA_W  operands; reqN_s  in  1  update status.
REQ-007 SHALL have ports: alu_command  out  4; alu_status_in  out  4; alu_operand1, alu_operand2  out  DATA_W  (drive shared ALU).
REQ-008 SHALL have ports: alu_result  in  DATA_W; alu_status  in  4  {N,Z,C,V} (ALU response, combinational).
REQ-009 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1  granted requester; rsp_result  out  DATA_W; rsp_status  out  4.
REQ-010 SHALL have port: status_q  out  4  architectural {N,Z,C,V} register.

Function
REQ-011 SHALL grant at most one requester per cycle; grant occurs only when that requester's valid and ready are both high.
REQ-012 SHALL drive the ALU inputs combinationally from the granted request; with no grant, it SHALL drive alu_command=0000 and zero operands.
REQ-013 SHALL drive alu_status_in from status_q; the ADC carry is status_q[1] as of the grant cycle.
REQ-014 SHALL register alu_result/alu_status into rsp_result/rsp_status and set rsp_valid at the edge ending the grant cycle (latency 1).
REQ-015 SHALL update status_q with alu_status at that same edge only if the granted reqN_s=1; otherwise status_q holds.
REQ-016 SHALL implement FSM IDLE (no response held) and RESP (rsp_valid=1).
REQ-017 SHALL transition IDLE->RESP on grant; RESP->IDLE on rsp_ready with no new grant; RESP->RESP on rsp_ready with a new grant, or when rsp_ready=0.
REQ-018 SHALL assert ready in IDLE, or in RESP when rsp_ready=1, so throughput is 1 op/cycle under no backpressure.
REQ-019 SHALL hold rsp_* stable while rsp_valid=1 and rsp_ready=0; ready is low to both requesters then.
REQ-020 SHALL, for back-to-back dependent ops, apply a status written by op k to the alu_status_in of op k+1 granted the next cycle.
REQ-021 SHALL, when both requesters are valid, grant per REQ-028; a lone valid requester is always eligible.

Reset
REQ-022 SHALL on rst: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_status=0, status_q=0000, FSM=IDLE, round-robin pointer=req0 preferred.
REQ-023 SHALL discard a response held in RESP when rst asserts mid-operation; no grant occurs during a reset cycle (ready=0).

Configuration
REQ-024 SHALL recognise macro ALU_ARB_RR_EN.
REQ-025 SHALL, when ALU_ARB_RR_EN is defined, arbitrate round-robin: after granting reqN, the other requester wins the next contention.
REQ-026 SHALL, when ALU_ARB_RR_EN is undefined, use fixed priority req0 > req1 and omit the pointer register.
REQ-027 SHALL otherwise behave identically in both builds.
REQ-028 SHALL apply the selected policy for REQ-021.

Structure
REQ-029 SHALL place in shared package alu_arb_pkg: ALU command constants (MOV 0001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MVN 1001), FSM state enum, status bit indices N=3,Z=2,C=1,V=0.
REQ-030 SHALL isolate grant logic in sub-module arb_rr2 (2-way, pointer + fixed-priority fallback).
REQ-031 SHALL keep the ALU external; this block instantiates no ALU.

Verification
REQ-032 SHALL verify: req0 ADD 0x7FFFFFFF+0x00000001 s=1 -> next cycle rsp_result=0x80000000, rsp_status=status_q=1001.
REQ-033 SHALL verify: req0 ADD 0xFFFFFFFF+0x00000001 s=1, then ADC 0+0 next cycle -> results 0x00000000 (status 0110) then 0x00000001.
REQ-034 SHALL verify: both valid for 4 cycles with RR_EN -> rsp_id 0,1,0,1; without RR_EN -> 0,0,0,0.
REQ-035 SHALL verify: rsp_ready=0 for 3 cycles while in RESP -> rsp_* stable, req ready=0, no status change; rsp_ready=1 -> next grant proceeds.
REQ-036 SHALL verify: rst asserted while in RESP -> next cycle rsp_valid=0, status_q=0000, FSM=IDLE.
REQ-037 SHALL verify: s=0 SUB 5-7 after status 1001 -> rsp_result=0xFFFFFFFE, status_q remains 1001.
